// File: rtl/mmu_boot_seq.sv
// Boot-map loader and CPU write arbiter for the MinTZ80 MMU page-map register file.
// Owns the $D1 unlock/lock gate and drives the Z80 WAIT line.
module mmu_boot_seq #(
    parameter logic [23:0] BOOT_MAP = 24'o11111110,
    parameter int          ENTRIES  = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       cpu_req,
    input  logic [2:0] cpu_adr,
    input  logic [2:0] cpu_data,
    input  logic       lock_rd,
    input  logic       lock_wr,
    output logic       cpu_ack,
    output logic       wait_n,
    output logic       mm_we,
    output logic [2:0] mm_adr,
    output logic [2:0] mm_data,
    output logic       locked,
    output logic       busy,
    output logic       done
);

    localparam logic [2:0] LAST_IDX = 3'(ENTRIES - 1);

    typedef enum logic [2:0] {
        ST_UNLOCK = 3'd0,
        ST_WRITE  = 3'd1,
        ST_LOCK   = 3'd2,
        ST_IDLE   = 3'd3,
        ST_GRANT  = 3'd4
    } state_t;

    state_t     state_r;
    logic [2:0] idx_r;
    logic       armed_r;
    logic       locked_nxt_s;
    logic       grant_s;

    function automatic logic [2:0] boot_entry(input logic [2:0] i);
        return BOOT_MAP[int'(i) * 3 +: 3];
    endfunction

    // Lock gate next value: a same-cycle lock write wins over the unlock read.
    always_comb begin
        locked_nxt_s = locked;
        if (lock_wr) begin
            locked_nxt_s = 1'b1;
        end else if (lock_rd) begin
            locked_nxt_s = 1'b0;
        end else begin
            locked_nxt_s = locked;
        end
    end

    // A grant is only taken from IDLE, behind start, and once per request.
    always_comb begin
        grant_s = 1'b0;
        if (state_r == ST_IDLE && !start && cpu_req && armed_r) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // WAIT is held inactive in reset so the CPU is never stalled by a dead sequencer.
    assign wait_n = ~(reset & cpu_req & ~cpu_ack);

    // Sequencer state, lock gate and all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_UNLOCK;
            idx_r   <= 3'd0;
            armed_r <= 1'b1;
            locked  <= 1'b1;
            busy    <= 1'b1;
            done    <= 1'b0;
            mm_we   <= 1'b0;
            mm_adr  <= 3'd0;
            mm_data <= 3'd0;
            cpu_ack <= 1'b0;
        end else begin
            locked  <= locked_nxt_s;
            mm_we   <= 1'b0;
            cpu_ack <= 1'b0;

            if (!cpu_req) begin
                armed_r <= 1'b1;
            end else if (grant_s) begin
                armed_r <= 1'b0;
            end else begin
                armed_r <= armed_r;
            end

            case (state_r)
                ST_UNLOCK: begin
                    state_r <= ST_WRITE;
                    idx_r   <= 3'd0;
                    mm_we   <= 1'b1;
                    mm_adr  <= 3'd0;
                    mm_data <= boot_entry(3'd0);
                end
                ST_WRITE: begin
                    if (idx_r == LAST_IDX) begin
                        state_r <= ST_LOCK;
                    end else begin
                        idx_r   <= idx_r + 3'd1;
                        mm_we   <= 1'b1;
                        mm_adr  <= idx_r + 3'd1;
                        mm_data <= boot_entry(idx_r + 3'd1);
                    end
                end
                ST_LOCK: begin
                    // Closing the gate here overrides any unlock read this cycle.
                    locked  <= 1'b1;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    state_r <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (start) begin
                        state_r <= ST_UNLOCK;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                    end else if (grant_s) begin
                        state_r <= ST_GRANT;
                        cpu_ack <= 1'b1;
                        mm_we   <= ~locked_nxt_s;
                        mm_adr  <= cpu_adr;
                        mm_data <= cpu_data;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_UNLOCK;
                    idx_r   <= 3'd0;
                    busy    <= 1'b1;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
